// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control unit: a Moore FSM that sequences fetch, decode,
// execute, memory and writeback on a shared instruction/data memory.
// Datapath controls are decoded combinationally from the current state.
// A few of them also depend on mem_ready, Zero or Funct.
module mc_control_unit #(
  parameter bit EN_BNE        = 1'b1,
  parameter bit EN_ADDI       = 1'b1,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opCode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t cur, nxt;
  logic   rdy;
  logic   funct_ok;
  logic [2:0] funct_alu;

  // Raw controls before the reset gate on the write/strobe outputs
  logic r_mem_req, r_memwrite, r_irwrite, r_regwrite, r_pcen, r_illegal;

  assign rdy   = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign state = cur;

  // R-type funct decode to ALU operation
  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (Funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase
  end

  // Next-state logic and per-state control decode
  always_comb begin
    nxt        = S_FETCH;
    r_mem_req  = 1'b0;
    IorD       = 1'b0;
    r_memwrite = 1'b0;
    r_irwrite  = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    r_regwrite = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    PCSrc      = 2'b00;
    r_pcen     = 1'b0;
    r_illegal  = 1'b0;
    case (cur)
      S_FETCH: begin
        r_mem_req = 1'b1;
        ALUSrcB   = 2'b01;
        r_irwrite = rdy;
        r_pcen    = rdy;
        nxt       = rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (opCode)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_RTYPE:     nxt = S_EXECUTE;
          OP_BEQ:       nxt = S_BRANCH;
          OP_BNE: begin
            if (EN_BNE) nxt = S_BRANCH;
            else        r_illegal = 1'b1;
          end
          OP_ADDI: begin
            if (EN_ADDI) nxt = S_ADDIEXEC;
            else         r_illegal = 1'b1;
          end
          OP_J:         nxt = S_JUMP;
          default:      r_illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (opCode == OP_LW)      nxt = S_MEMREAD;
        else if (opCode == OP_SW) nxt = S_MEMWRITE;
      end
      S_MEMREAD: begin
        r_mem_req = 1'b1;
        IorD      = 1'b1;
        nxt       = rdy ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        r_regwrite = 1'b1;
      end
      S_MEMWRITE: begin
        r_mem_req  = 1'b1;
        IorD       = 1'b1;
        r_memwrite = 1'b1;
        nxt        = rdy ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTE: begin
        ALUSrcA    = 1'b1;
        ALUControl = funct_alu;
        if (funct_ok) nxt = S_ALUWB;
        else          r_illegal = 1'b1;
      end
      S_ALUWB: begin
        RegDst     = 1'b1;
        r_regwrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        PCSrc      = 2'b01;
        r_pcen     = (opCode == OP_BNE) ? ~Zero : Zero;
      end
      S_ADDIEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        nxt     = S_ADDIWB;
      end
      S_ADDIWB: r_regwrite = 1'b1;
      S_JUMP: begin
        PCSrc  = 2'b10;
        r_pcen = 1'b1;
      end
      default: nxt = S_FETCH;
    endcase
  end

  // Strobes are held low during reset so nothing writes on the reset edge
  assign mem_req  = r_mem_req  & rst;
  assign MemWrite = r_memwrite & rst;
  assign IRWrite  = r_irwrite  & rst;
  assign RegWrite = r_regwrite & rst;
  assign PCEn     = r_pcen     & rst;
  assign illegal  = r_illegal  & rst;

  // State register, async active-low reset to FETCH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cur <= S_FETCH;
    else      cur <= nxt;
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit. A second instance built without addi
// runs on the same inputs. It exercises the illegal-opcode path.
module tb_mc_control_unit;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] opCode = 6'd0, Funct = 6'd0;
  logic       Zero = 1'b0, mem_ready = 1'b1;

  logic       mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn, illegal;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;

  logic       b_mem_req, b_IorD, b_MemWrite, b_IRWrite, b_RegDst, b_MemtoReg, b_RegWrite, b_ALUSrcA, b_PCEn, b_illegal;
  logic [1:0] b_ALUSrcB, b_PCSrc;
  logic [2:0] b_ALUControl;
  logic [3:0] b_state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mc_control_unit dut (
    .clk(clk), .rst(rst), .opCode(opCode), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .PCSrc(PCSrc), .PCEn(PCEn), .illegal(illegal), .state(state)
  );

  mc_control_unit #(.EN_BNE(1'b1), .EN_ADDI(1'b0), .MEM_HANDSHAKE(1'b1)) dut_na (
    .clk(clk), .rst(rst), .opCode(opCode), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
    .mem_req(b_mem_req), .IorD(b_IorD), .MemWrite(b_MemWrite), .IRWrite(b_IRWrite), .RegDst(b_RegDst),
    .MemtoReg(b_MemtoReg), .RegWrite(b_RegWrite), .ALUSrcA(b_ALUSrcA), .ALUSrcB(b_ALUSrcB),
    .ALUControl(b_ALUControl), .PCSrc(b_PCSrc), .PCEn(b_PCEn), .illegal(b_illegal), .state(b_state)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset: state FETCH, strobes low, other outputs at FETCH values
    #2;
    chk("rst_state", {4'd0, state}, 8'd0);
    chk("rst_memreq", {7'd0, mem_req}, 8'd0);
    chk("rst_irwrite", {7'd0, IRWrite}, 8'd0);
    chk("rst_pcen", {7'd0, PCEn}, 8'd0);
    chk("rst_alusrcb", {6'd0, ALUSrcB}, 8'd1);
    chk("rst_aluctl", {5'd0, ALUControl}, 8'd2);
    @(negedge clk);
    rst = 1'b1;

    // lw, zero-wait: 0,1,2,3,4,0
    opCode = 6'b100011; mem_ready = 1'b1;
    #1;
    chk("lw_f_state", {4'd0, state}, 8'd0);
    chk("lw_f_memreq", {7'd0, mem_req}, 8'd1);
    chk("lw_f_irwrite", {7'd0, IRWrite}, 8'd1);
    chk("lw_f_pcen", {7'd0, PCEn}, 8'd1);
    tick();
    chk("lw_d_state", {4'd0, state}, 8'd1);
    chk("lw_d_alusrcb", {6'd0, ALUSrcB}, 8'd3);
    chk("lw_d_regwrite", {7'd0, RegWrite}, 8'd0);
    tick();
    chk("lw_a_state", {4'd0, state}, 8'd2);
    chk("lw_a_src", {5'd0, ALUSrcA, ALUSrcB}, 8'b110);
    tick();
    chk("lw_r_state", {4'd0, state}, 8'd3);
    chk("lw_r_req_iord", {6'd0, mem_req, IorD}, 8'b11);
    chk("lw_r_regwrite", {7'd0, RegWrite}, 8'd0);
    tick();
    chk("lw_wb_state", {4'd0, state}, 8'd4);
    chk("lw_wb_wr", {6'd0, RegWrite, MemtoReg}, 8'b11);
    tick();
    chk("lw_done_state", {4'd0, state}, 8'd0);

    // sw with 3 wait cycles in MEMWRITE: 7 cycles total
    opCode = 6'b101011;
    tick(); tick(); tick();
    chk("sw_state", {4'd0, state}, 8'd5);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("sw_wait_strobe", {6'd0, MemWrite, mem_req}, 8'b11);
      tick();
      chk("sw_wait_state", {4'd0, state}, 8'd5);
    end
    mem_ready = 1'b1;
    #1;
    chk("sw_last_strobe", {6'd0, MemWrite, mem_req}, 8'b11);
    tick();
    chk("sw_done_state", {4'd0, state}, 8'd0);
    chk("sw_done_memwrite", {7'd0, MemWrite}, 8'd0);

    // R-type slt
    opCode = 6'b000000; Funct = 6'b101010;
    tick(); tick();
    chk("slt_state", {4'd0, state}, 8'd6);
    chk("slt_aluctl", {5'd0, ALUControl}, 8'b111);
    chk("slt_illegal", {7'd0, illegal}, 8'd0);
    tick();
    chk("slt_wb_state", {4'd0, state}, 8'd7);
    chk("slt_wb", {6'd0, RegDst, RegWrite}, 8'b11);
    tick();
    chk("slt_done", {4'd0, state}, 8'd0);

    // R-type with bad funct
    Funct = 6'b000000;
    tick(); tick();
    chk("badf_state", {4'd0, state}, 8'd6);
    chk("badf_illegal", {7'd0, illegal}, 8'd1);
    chk("badf_regwrite", {7'd0, RegWrite}, 8'd0);
    tick();
    chk("badf_back", {4'd0, state}, 8'd0);
    chk("badf_illegal_off", {7'd0, illegal}, 8'd0);

    // beq taken / not taken
    opCode = 6'b000100; Zero = 1'b1;
    tick(); tick();
    chk("beq_state", {4'd0, state}, 8'd8);
    chk("beq_pcen", {7'd0, PCEn}, 8'd1);
    chk("beq_pcsrc_alu", {3'd0, PCSrc, ALUControl}, 8'b01110);
    Zero = 1'b0;
    #1;
    chk("beq_nz_pcen", {7'd0, PCEn}, 8'd0);
    tick();
    chk("beq_done", {4'd0, state}, 8'd0);

    // bne with Zero=1: not taken
    opCode = 6'b000101; Zero = 1'b1;
    tick(); tick();
    chk("bne_state", {4'd0, state}, 8'd8);
    chk("bne_pcen", {7'd0, PCEn}, 8'd0);
    tick();

    // jump
    opCode = 6'b000010;
    tick(); tick();
    chk("j_state", {4'd0, state}, 8'd11);
    chk("j_pc", {5'd0, PCSrc, PCEn}, 8'b101);
    tick();
    chk("j_done", {4'd0, state}, 8'd0);

    // addi: supported on dut, illegal on dut_na
    opCode = 6'b001000;
    tick();
    chk("addi_dec", {4'd0, state}, 8'd1);
    chk("na_dec_illegal", {7'd0, b_illegal}, 8'd1);
    chk("addi_dec_illegal", {7'd0, illegal}, 8'd0);
    tick();
    chk("addi_exec_state", {4'd0, state}, 8'd9);
    chk("na_back_fetch", {4'd0, b_state}, 8'd0);
    chk("na_no_regwrite", {7'd0, b_RegWrite}, 8'd0);
    tick();
    chk("addi_wb_state", {4'd0, state}, 8'd10);
    chk("addi_wb", {5'd0, RegWrite, MemtoReg, RegDst}, 8'b100);
    chk("na_regwrite2", {7'd0, b_RegWrite}, 8'd0);
    tick();
    chk("addi_done", {4'd0, state}, 8'd0);

    // Reset during a MEMREAD wait
    opCode = 6'b100011;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    #1;
    chk("rr_state", {4'd0, state}, 8'd3);
    chk("rr_memreq", {7'd0, mem_req}, 8'd1);
    rst = 1'b0;
    #1;
    chk("rr_rst_state", {4'd0, state}, 8'd0);
    chk("rr_rst_enables", {2'd0, mem_req, MemWrite, IRWrite, RegWrite, PCEn, illegal}, 8'd0);
    tick();
    chk("rr_rst_hold", {4'd0, state}, 8'd0);
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b1;
    #1;
    chk("rr_fetch_irwrite", {6'd0, mem_req, IRWrite}, 8'b11);
    tick();
    chk("rr_resume", {4'd0, state}, 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a hung run
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
